decode_stage: RTL and testbench

Registered RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides. It sits between fetch and register-read/execute and covers all base formats (R, I, S, B, U, J), plus optional M-extension decode and illegal-instruction detection. A two-entry skid buffer sustains one instruction per cycle under back-pressure, and a synchronous flush discards in-flight entries on redirects.

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/decode_comb.sv | 95 +++++++++
 rtl/decode_stage.sv | 94 +++++++++
 tb/tb_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - RV32I/RV64I major opcode constants
//   - fmt_e format codes: R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//   - aluop bit positions
//   - dec_pkt_t, the decoded packet stored by the stage buffers
// The immediate is held as a 32-bit sign-extended value. Every base-ISA
// immediate fits in 32 bits, so the stage widens it to XLEN at its output.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // aluop = {m_op, funct7[5], funct3}
  localparam int ALUOP_MOP_BIT  = 4;
  localparam int ALUOP_F7B5_BIT = 3;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  aluop;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        wrt_en;
    logic        illegal;
  } dec_pkt_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I/RV64I (+ optional M) instruction decoder.
//   ins  in   32-bit raw instruction word
//   pkt  out  decoded packet (dec_pkt_t)
// Parameters: XLEN (32/64) selects the shift-amount width used for the
// OP-IMM shift legality check; M_EXT enables funct7=0000001 in OP.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0] ins,
  output dec_pkt_t    pkt
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       shift_ok;
  logic       op_ok;

  always_comb begin
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[31:25];

    // RV64 shifts use a 6-bit shamt, so ins[25] belongs to the amount.
    if (XLEN == 64)
      shift_ok = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000);
    else
      shift_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    op_ok = (funct7 == 7'b0000000)
         || ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
         || ((funct7 == 7'b0000001) && M_EXT);

    pkt     = '0;
    pkt.fmt = FMT_ILL;

    case (opcode)
      OPC_OP_IMM: begin
        pkt.fmt     = FMT_I;
        pkt.rs1     = ins[19:15];
        pkt.rd      = ins[11:7];
        pkt.imm     = sext12(ins[31:20]);
        pkt.aluop   = {1'b0, (funct3 == 3'b101) & ins[30], funct3};
        pkt.illegal = ((funct3 == 3'b001) || (funct3 == 3'b101)) && !shift_ok;
      end
      OPC_LOAD, OPC_JALR: begin
        pkt.fmt   = FMT_I;
        pkt.rs1   = ins[19:15];
        pkt.rd    = ins[11:7];
        pkt.imm   = sext12(ins[31:20]);
        pkt.aluop = {2'b00, funct3};
      end
      OPC_OP: begin
        pkt.fmt     = FMT_R;
        pkt.rs1     = ins[19:15];
        pkt.rs2     = ins[24:20];
        pkt.rd      = ins[11:7];
        pkt.aluop   = {M_EXT && (funct7 == 7'b0000001), ins[30], funct3};
        pkt.illegal = !op_ok;
      end
      OPC_STORE: begin
        pkt.fmt   = FMT_S;
        pkt.rs1   = ins[19:15];
        pkt.rs2   = ins[24:20];
        pkt.imm   = sext12({ins[31:25], ins[11:7]});
        pkt.aluop = {2'b00, funct3};
      end
      OPC_BRANCH: begin
        pkt.fmt   = FMT_B;
        pkt.rs1   = ins[19:15];
        pkt.rs2   = ins[24:20];
        pkt.imm   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        pkt.aluop = {2'b00, funct3};
      end
      OPC_LUI, OPC_AUIPC: begin
        pkt.fmt = FMT_U;
        pkt.rd  = ins[11:7];
        pkt.imm = {ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        pkt.fmt = FMT_J;
        pkt.rd  = ins[11:7];
        pkt.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: pkt.illegal = 1'b1;
    endcase

    // rd is only populated for R/I/U/J, so a nonzero rd implies a writing format.
    pkt.wrt_en = !pkt.illegal && (pkt.rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with valid/ready on both sides.
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop both buffered entries
//   in_valid/in_ready    upstream handshake; in_ins, in_pc
//   out_valid/out_ready  downstream handshake
//   out_pc, out_rs1/rs2/rd, out_aluop, out_imm, out_fmt, out_wrt_en, out_illegal
// Storage is the output register plus one skid entry, both holding decoded
// packets. in_ready depends only on skid occupancy, so it never combinationally
// follows out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_aluop,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_wrt_en,
  output logic            out_illegal
);

  dec_pkt_t        dec_pkt;
  dec_pkt_t        out_pkt;
  dec_pkt_t        skid_pkt;
  logic [XLEN-1:0] skid_pc;
  logic            skid_valid;
  logic            accept;
  logic            out_free;

  decode_comb #(.XLEN(XLEN), .M_EXT(M_EXT)) u_decode_comb (
    .ins (in_ins),
    .pkt (dec_pkt)
  );

  assign in_ready = rst_n && !skid_valid && !flush;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pkt    <= '0;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_pkt   <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      // skid is older than anything arriving now; accept is blocked while skid is full
      if (skid_valid) begin
        out_pkt    <= skid_pkt;
        out_pc     <= skid_pc;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_pkt   <= dec_pkt;
        out_pc    <= in_pc;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_pkt   <= dec_pkt;
      skid_pc    <= in_pc;
      skid_valid <= 1'b1;
    end
  end

  assign out_rs1     = out_pkt.rs1;
  assign out_rs2     = out_pkt.rs2;
  assign out_rd      = out_pkt.rd;
  assign out_aluop   = out_pkt.aluop;
  assign out_imm     = XLEN'($signed(out_pkt.imm));
  assign out_fmt     = out_pkt.fmt;
  assign out_wrt_en  = out_pkt.wrt_en;
  assign out_illegal = out_pkt.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (XLEN=32/M_EXT=0 and XLEN=64/M_EXT=1)
// share one stimulus stream. A queue-based occupancy model plus an
// instruction-level decode model predict every output; directed literal
// checks pin the model on hand-decoded words.
module tb_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_ins;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_wrt, a_ill;
  logic [31:0] a_out_pc, a_out_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_aluop;
  logic [2:0]  a_fmt;

  logic        b_in_ready, b_out_valid, b_wrt, b_ill;
  logic [63:0] b_out_pc, b_out_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_aluop;
  logic [2:0]  b_fmt;

  decode_stage #(.XLEN(32), .M_EXT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ins(in_ins), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_aluop(a_aluop),
    .out_imm(a_out_imm), .out_fmt(a_fmt), .out_wrt_en(a_wrt), .out_illegal(a_ill)
  );

  decode_stage #(.XLEN(64), .M_EXT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_aluop(b_aluop),
    .out_imm(b_out_imm), .out_fmt(b_fmt), .out_wrt_en(b_wrt), .out_illegal(b_ill)
  );

  localparam logic [31:0] I_ADDI  = 32'hFFF10093; // addi x1,x2,-1
  localparam logic [31:0] I_SUB   = 32'h405201B3; // sub x3,x4,x5
  localparam logic [31:0] I_MUL   = 32'h025201B3; // mul x3,x4,x5
  localparam logic [31:0] I_SW    = 32'h00512423; // sw x5,8(x2)
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] I_ZERO  = 32'h00000000;
  localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
  localparam logic [31:0] I_SRAI  = 32'h4210D093; // srai x1,x1,33 (RV64 only)
  localparam logic [31:0] I_LUI   = 32'h800002B7; // lui x5,0x80000
  localparam logic [31:0] I_JAL   = 32'hFF9FF0EF; // jal x1,-8
  localparam logic [31:0] I_NOP   = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_BADOP = 32'h405221B3; // funct7=0100000 with funct3=010

  typedef struct { logic [31:0] ins; logic [63:0] pc; } ent_t;
  typedef struct packed {
    logic [4:0] rs1, rs2, rd, aluop;
    logic [63:0] imm;
    logic [2:0] fmt;
    logic wrt, ill;
  } exp_t;

  ent_t        q[$];
  bit          m_acc   = 1'b0;
  bit          started = 1'b0;
  int          n_pass  = 0;
  int          n_total = 0;
  int          cnt_acc = 0;
  int          cnt_out = 0;
  logic [63:0] pc_next = 64'h0000_0001_8000_0000;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Instruction-level decode rules written from the ISA encodings.
  function automatic exp_t model(input logic [31:0] ins, input bit x64, input bit mext);
    exp_t       e;
    longint     s, hi;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    e = '0;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    s = longint'(signed'(ins));
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e.fmt = 3'd1; e.rs1 = ins[19:15]; e.rd = ins[11:7];
        hi = s >>> 20; e.imm = hi;
        if (opc == 7'b0010011) begin
          e.aluop = {1'b0, (f3 == 3'd5) ? ins[30] : 1'b0, f3};
          if (f3 == 3'd1 || f3 == 3'd5)
            e.ill = x64 ? !(ins[31:26] == 6'd0 || ins[31:26] == 6'b010000)
                        : !(f7 == 7'd0 || f7 == 7'b0100000);
        end else e.aluop = {2'b00, f3};
      end
      7'b0110011: begin
        e.fmt = 3'd0; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.aluop = {mext && (f7 == 7'b0000001), ins[30], f3};
        e.ill = !((f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))
                  || (f7 == 7'b0000001 && mext));
      end
      7'b0100011: begin
        e.fmt = 3'd2; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.aluop = {2'b00, f3};
        hi = s >>> 25; e.imm = (hi << 5) | 64'(ins[11:7]);
      end
      7'b1100011: begin
        e.fmt = 3'd3; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.aluop = {2'b00, f3};
        hi = s >>> 31;
        e.imm = (hi << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4; e.rd = ins[11:7];
        hi = s >>> 12; e.imm = hi << 12;
      end
      7'b1101111: begin
        e.fmt = 3'd5; e.rd = ins[11:7];
        hi = s >>> 31;
        e.imm = (hi << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      end
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    e.wrt = !e.ill && (e.rd != 5'd0) && (e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5});
    return e;
  endfunction

  function automatic bit m_in_ready();
    return (rst_n === 1'b1) && (q.size() < 2) && (flush === 1'b0);
  endfunction

  // Occupancy model: FIFO of at most two accepted instructions.
  initial forever begin
    bit acc;
    @(posedge clk);
    m_acc = 1'b0;
    if (!rst_n || flush) q.delete();
    else begin
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back('{in_ins, in_pc});
      m_acc = acc;
    end
    started = 1'b1;
  end

  task automatic check_pkt(input string tag, input bit x64, input bit mext, input ent_t e,
                           input logic [63:0] pc, input logic [63:0] imm,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [4:0] aluop, input logic [2:0] fmt,
                           input logic wrt, input logic ill);
    exp_t        x;
    logic [63:0] xpc, ximm;
    x    = model(e.ins, x64, mext);
    xpc  = x64 ? e.pc : {32'd0, e.pc[31:0]};
    ximm = x64 ? x.imm : {32'd0, x.imm[31:0]};
    if (x.ill)
      chk({tag, "_illegal_pkt"}, {ill, wrt, pc}, {1'b1, 1'b0, xpc});
    else
      chk({tag, "_pkt"}, {pc, imm, rs1, rs2, rd, aluop, fmt, wrt, ill},
          {xpc, ximm, x.rs1, x.rs2, x.rd, x.aluop, x.fmt, x.wrt, 1'b0});
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("a_in_ready", a_in_ready, m_in_ready());
      chk("b_in_ready", b_in_ready, m_in_ready());
      chk("a_out_valid", a_out_valid, q.size() > 0);
      chk("b_out_valid", b_out_valid, q.size() > 0);
      if (q.size() > 0) begin
        check_pkt("a", 1'b0, 1'b0, q[0], {32'd0, a_out_pc}, {32'd0, a_out_imm},
                  a_rs1, a_rs2, a_rd, a_aluop, a_fmt, a_wrt, a_ill);
        check_pkt("b", 1'b1, 1'b1, q[0], b_out_pc, b_out_imm,
                  b_rs1, b_rs2, b_rd, b_aluop, b_fmt, b_wrt, b_ill);
      end
      if (in_valid && a_in_ready) cnt_acc++;
      if (a_out_valid && out_ready && rst_n && !flush) cnt_out++;
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    in_valid = v; in_ins = ins; out_ready = rdy; flush = fl; in_pc = pc_next;
    @(posedge clk); #1;
    if (m_acc) pc_next += 64'd4;
  endtask

  task automatic fill_two();
    step(1'b1, I_ADDI, 1'b0, 1'b0);
    step(1'b1, I_SUB, 1'b0, 1'b0);
  endtask

  logic [31:0] stream [5] = '{I_ADDI, I_SUB, I_SW, I_BEQ, I_LUI};
  logic [31:0] mix    [8] = '{I_JAL, I_NOP, I_SRAI, I_MUL, I_ONES, I_BADOP, I_BEQ, I_ADDI};
  logic [9:0]  rdy_pat = 10'b1011001101;

  initial begin
    int k, guard, base_acc, base_out;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ins = '0; out_ready = 1'b1; in_pc = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_a_outputs", {a_out_valid, a_out_pc, a_out_imm, a_rs1, a_rs2, a_rd, a_aluop, a_fmt, a_wrt, a_ill}, '0);
    chk("reset_in_ready", a_in_ready, 1'b0);
    rst_n = 1'b1; #1;
    chk("release_in_ready", a_in_ready, 1'b1);

    step(1'b1, I_ADDI, 1'b1, 1'b0);
    chk("addi_fields", {a_out_valid, a_rs1, a_rd, a_aluop, a_fmt, a_wrt, a_ill},
        {1'b1, 5'd2, 5'd1, 5'b00000, 3'd1, 1'b1, 1'b0});
    chk("addi_imm32", a_out_imm, 32'hFFFFFFFF);
    chk("addi_imm64", b_out_imm, 64'hFFFFFFFF_FFFFFFFF);
    step(1'b1, I_SUB, 1'b1, 1'b0);
    chk("sub_fields", {a_aluop, a_rs2, a_out_imm}, {5'b01000, 5'd5, 32'd0});
    step(1'b1, I_MUL, 1'b1, 1'b0);
    chk("mul_mext_aluop", {b_aluop, b_ill}, {5'b10000, 1'b0});
    chk("mul_nomext_illegal", {a_ill, a_wrt}, {1'b1, 1'b0});
    step(1'b1, I_SW, 1'b1, 1'b0);
    chk("sw_fields", {a_fmt, a_out_imm, a_wrt, a_rd}, {3'd2, 32'd8, 1'b0, 5'd0});
    step(1'b1, I_BEQ, 1'b1, 1'b0);
    chk("beq_fields", {a_fmt, a_out_imm}, {3'd3, 32'hFFFFFFFC});
    step(1'b1, I_ZERO, 1'b1, 1'b0);
    chk("zero_illegal", {a_ill, a_wrt}, {1'b1, 1'b0});
    step(1'b1, I_ONES, 1'b1, 1'b0);
    chk("ones_illegal", {b_ill, b_wrt}, {1'b1, 1'b0});
    step(1'b1, I_SRAI, 1'b1, 1'b0);
    chk("srai_shamt_width", {a_ill, b_ill, b_aluop}, {1'b1, 1'b0, 5'b01101});
    step(1'b1, I_LUI, 1'b1, 1'b0);
    chk("lui_imm", {a_out_imm, b_out_imm}, {32'h80000000, 64'hFFFFFFFF_80000000});
    step(1'b1, I_JAL, 1'b1, 1'b0);
    chk("jal_fields", {a_out_imm, a_fmt, a_rd, a_wrt}, {32'hFFFFFFF8, 3'd5, 5'd1, 1'b1});
    step(1'b1, I_NOP, 1'b1, 1'b0);
    chk("nop_x0_no_write", a_wrt, 1'b0);
    step(1'b1, I_BADOP, 1'b1, 1'b0);
    chk("badop_illegal", {a_ill, b_ill}, {1'b1, 1'b1});
    step(1'b0, I_ZERO, 1'b1, 1'b0);

    // back-pressure: five instructions, consumer stalled for three cycles
    k = 0; base_acc = cnt_acc; base_out = cnt_out;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, stream[k], 1'b0, 1'b0);
      if (m_acc) k++;
    end
    chk("bp_accepts_while_stalled", cnt_acc - base_acc, 2);
    chk("bp_in_ready_low", a_in_ready, 1'b0);
    guard = 0;
    while (k < 5 && guard < 20) begin
      step(1'b1, stream[k], 1'b1, 1'b0);
      if (m_acc) k++;
      guard++;
    end
    if (k < 5) begin
      n_total++;
      $display("FAIL bp_stream_timeout: got %0d accepted expected 5", k);
    end
    for (int c = 0; c < 3; c++) step(1'b0, I_ZERO, 1'b1, 1'b0);
    chk("bp_output_count", cnt_out - base_out, 5);

    // irregular consumer pattern
    k = 0; guard = 0;
    while (k < 8 && guard < 40) begin
      step(1'b1, mix[k], rdy_pat[guard % 10], 1'b0);
      if (m_acc) k++;
      guard++;
    end
    for (int c = 0; c < 3; c++) step(1'b0, I_ZERO, 1'b1, 1'b0);

    // flush with both entries full; the flush-cycle input must be dropped
    fill_two();
    chk("flush_pre_full", a_in_ready, 1'b0);
    base_acc = cnt_acc;
    step(1'b1, I_SW, 1'b1, 1'b1);
    chk("flush_out_valid", a_out_valid, 1'b0);
    chk("flush_no_accept", cnt_acc - base_acc, 0);
    step(1'b0, I_ZERO, 1'b1, 1'b0);
    chk("flush_nothing_after", {a_out_valid, b_out_valid}, 2'b00);

    // reset mid-stream with both entries full
    fill_two();
    rst_n = 1'b0;
    step(1'b1, I_BEQ, 1'b1, 1'b0);
    chk("midrst_a_zero", {a_out_valid, a_out_pc, a_out_imm, a_rs1, a_rs2, a_rd, a_aluop, a_fmt, a_wrt, a_ill}, '0);
    chk("midrst_b_zero", {b_out_valid, b_out_pc, b_out_imm, b_rs1, b_rs2, b_rd, b_aluop, b_fmt, b_wrt, b_ill}, '0);
    chk("midrst_in_ready", a_in_ready, 1'b0);
    rst_n = 1'b1; #1;
    chk("midrst_release_ready", a_in_ready, 1'b1);
    step(1'b1, I_ADDI, 1'b1, 1'b0);
    chk("addi_again_imm64", {b_out_valid, b_out_imm}, {1'b1, 64'hFFFFFFFF_FFFFFFFF});
    step(1'b0, I_ZERO, 1'b1, 1'b0);
    step(1'b0, I_ZERO, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
